// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Two-requester round-robin arbiter in front of a single-port data memory.
// Master 0 is the core load/store path, master 1 a DMA/loader or debug port.
// Writes complete in the grant cycle, so back-to-back writes run every cycle.
// A read holds the memory for RD_LATENCY+1 cycles: the grant cycle, then
// RD_LATENCY cycles in RD_WAIT. In the last of those cycles mem_rdata is
// passed straight through to the owning master together with an rvalid pulse.
//
// Parameters
//   AW          address width
//   DW          data width
//   RD_LATENCY  cycles from address issue to valid mem_rdata (1..4)
//
// Ports
//   clk                  rising-edge clock
//   areset               asynchronous reset, active-high
//   m0_req / m1_req      access request, held with stable fields until gnt
//   m0_we / m1_we        1 = write, 0 = read
//   m0_addr / m1_addr    byte address
//   m0_wdata / m1_wdata  write data
//   m0_gnt / m1_gnt      request accepted this cycle (combinational)
//   m0_rvalid/m1_rvalid  one-cycle read-data-valid pulse
//   m0_rdata / m1_rdata  read data, zero except alongside rvalid
//   mem_we               memory write enable
//   mem_addr             memory address, zero when the memory is unused
//   mem_wdata            memory write data, zero unless writing
//   mem_rdata            memory read data
//   busy                 high while a read is outstanding
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic          clk,
  input  logic          areset,

  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,

  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,

  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,

  output logic          busy
);

  // The latency counter only has to reach RD_LATENCY.
  localparam int            CW       = $clog2(RD_LATENCY + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(RD_LATENCY);

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic          last_q,  last_d;   // id of the most recently granted master
  logic [CW-1:0] cnt_q,   cnt_d;    // read latency counter, 1..RD_LATENCY
  logic          rid_q,   rid_d;    // owner of the outstanding read
  logic [AW-1:0] raddr_q, raddr_d;  // address held on the memory during RD_WAIT

  // Arbitration
  logic          sel_valid;
  logic          sel_id;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;
  logic          rd_done;

  // Grants are suppressed while areset is asserted so that every output is
  // zero during reset, even with requests pending.
  assign sel_valid = (state_q == IDLE) && (m0_req || m1_req) && !areset;

  // A tie goes to the master that was not granted last; otherwise the sole
  // requester wins.
  assign sel_id    = (m0_req && m1_req) ? ~last_q : m1_req;

  assign win_we    = sel_id ? m1_we    : m0_we;
  assign win_addr  = sel_id ? m1_addr  : m0_addr;
  assign win_wdata = sel_id ? m1_wdata : m0_wdata;

  assign m0_gnt    = sel_valid && !sel_id;
  assign m1_gnt    = sel_valid &&  sel_id;

  // Memory side
  assign busy      = (state_q == RD_WAIT);
  assign mem_we    = sel_valid && win_we;
  assign mem_addr  = busy ? raddr_q : (sel_valid ? win_addr : '0);
  assign mem_wdata = mem_we ? win_wdata : '0;

  // Read completion: the memory output is passed through in the final
  // RD_WAIT cycle only, to the owner only.
  assign rd_done   = busy && (cnt_q == CNT_LAST);
  assign m0_rvalid = rd_done && !rid_q;
  assign m1_rvalid = rd_done &&  rid_q;
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    rid_d   = rid_q;
    raddr_d = raddr_q;
    unique case (state_q)
      IDLE: begin
        if (sel_valid) begin
          last_d = sel_id;
          // Writes finish in the grant cycle and stay in IDLE; reads park
          // the address and wait out the memory latency.
          if (!win_we) begin
            state_d = RD_WAIT;
            rid_d   = sel_id;
            raddr_d = win_addr;
            cnt_d   = CNT_ONE;
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers. last resets to 1 so that master 0 wins the first tie;
  // a reset during RD_WAIT simply drops the read.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      rid_q   <= 1'b0;
      raddr_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      rid_q   <= rid_d;
      raddr_q <= raddr_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Four arbiter instances with RD_LATENCY 1..4, each in front of its own
// behavioural memory (RD_LATENCY-stage registered read). Instance 1
// (RD_LATENCY=2) carries the directed scenarios; afterwards every instance
// gets random mixed traffic checked against a transaction-level reference:
// round-robin winner choice, no grants for RD_LATENCY cycles after a read
// grant, rvalid exactly RD_LATENCY cycles after the grant, and data equal to
// the last value written to that address.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int NI = 4;
  localparam int DI = 1;        // directed-test instance
  localparam int LD = DI + 1;   // its read latency

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic areset;

  logic [NI-1:0]       m0_req_v, m1_req_v, m0_we_v, m1_we_v;
  logic [NI-1:0][31:0] m0_addr_v, m1_addr_v, m0_wdata_v, m1_wdata_v;
  logic [NI-1:0]       m0_gnt_v, m1_gnt_v, m0_rvalid_v, m1_rvalid_v;
  logic [NI-1:0]       mem_we_v, busy_v;
  logic [NI-1:0][31:0] m0_rdata_v, m1_rdata_v, mem_addr_v, mem_wdata_v, mem_rdata_v;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] ref_mem [NI][64];

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    logic [31:0] mem_g  [64];
    logic [31:0] pipe_g [gi + 1];

    dmem_arbiter #(.AW(32), .DW(32), .RD_LATENCY(gi + 1)) u_dut (
      .clk       (clk),
      .areset    (areset),
      .m0_req    (m0_req_v[gi]),
      .m0_we     (m0_we_v[gi]),
      .m0_addr   (m0_addr_v[gi]),
      .m0_wdata  (m0_wdata_v[gi]),
      .m0_gnt    (m0_gnt_v[gi]),
      .m0_rvalid (m0_rvalid_v[gi]),
      .m0_rdata  (m0_rdata_v[gi]),
      .m1_req    (m1_req_v[gi]),
      .m1_we     (m1_we_v[gi]),
      .m1_addr   (m1_addr_v[gi]),
      .m1_wdata  (m1_wdata_v[gi]),
      .m1_gnt    (m1_gnt_v[gi]),
      .m1_rvalid (m1_rvalid_v[gi]),
      .m1_rdata  (m1_rdata_v[gi]),
      .mem_we    (mem_we_v[gi]),
      .mem_addr  (mem_addr_v[gi]),
      .mem_wdata (mem_wdata_v[gi]),
      .mem_rdata (mem_rdata_v[gi]),
      .busy      (busy_v[gi])
    );

    always @(posedge clk) begin
      if (mem_we_v[gi]) mem_g[mem_addr_v[gi][7:2]] <= mem_wdata_v[gi];
      pipe_g[0] <= mem_g[mem_addr_v[gi][7:2]];
      for (int s = 1; s < gi + 1; s++) pipe_g[s] <= pipe_g[s-1];
    end
    assign mem_rdata_v[gi] = pipe_g[gi];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_m0_gnt"},    32'(m0_gnt_v[DI]),    0);
    chk({tag, "_m1_gnt"},    32'(m1_gnt_v[DI]),    0);
    chk({tag, "_m0_rvalid"}, 32'(m0_rvalid_v[DI]), 0);
    chk({tag, "_m1_rvalid"}, 32'(m1_rvalid_v[DI]), 0);
    chk({tag, "_m0_rdata"},  m0_rdata_v[DI],       0);
    chk({tag, "_m1_rdata"},  m1_rdata_v[DI],       0);
    chk({tag, "_mem_we"},    32'(mem_we_v[DI]),    0);
    chk({tag, "_mem_addr"},  mem_addr_v[DI],       0);
    chk({tag, "_mem_wdata"}, mem_wdata_v[DI],      0);
    chk({tag, "_busy"},      32'(busy_v[DI]),      0);
  endtask

  task automatic drive(input int k, input bit who, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (!who) begin
      m0_req_v[k] = req; m0_we_v[k] = we; m0_addr_v[k] = addr; m0_wdata_v[k] = wdata;
    end else begin
      m1_req_v[k] = req; m1_we_v[k] = we; m1_addr_v[k] = addr; m1_wdata_v[k] = wdata;
    end
  endtask

  initial begin
    int c0, c1, lat, c, blk, prev, rvc;
    bit p0, p1, g0, g1, rvp, rvid, e0, e1, gen;
    logic we0, we1;
    logic [31:0] a0, a1, d0, d1, rvd, dat;

    for (int k = 0; k < NI; k++)
      for (int w = 0; w < 64; w++) ref_mem[k][w] = '0;
    m0_req_v = '0; m1_req_v = '0; m0_we_v = '0; m1_we_v = '0;
    m0_addr_v = '0; m1_addr_v = '0; m0_wdata_v = '0; m1_wdata_v = '0;
    areset = 1'b1;

    // Reset: outputs stay zero even with both masters requesting
    @(negedge clk);
    drive(DI, 0, 1, 1, 32'h20, 32'h1111);
    drive(DI, 1, 1, 0, 32'h24, 32'h2222);
    #2 chk_zero("rst_hold");
    @(negedge clk);
    areset = 1'b0;
    drive(DI, 0, 0, 0, 0, 0);
    drive(DI, 1, 0, 0, 0, 0);
    #2 chk_zero("rst_after");

    // 1: m0 write lands in the grant cycle
    @(negedge clk);
    drive(DI, 0, 1, 1, 32'h10, 32'hDEADBEEF);
    #2;
    chk("t1_m0_gnt",    32'(m0_gnt_v[DI]), 1);
    chk("t1_m1_gnt",    32'(m1_gnt_v[DI]), 0);
    chk("t1_mem_we",    32'(mem_we_v[DI]), 1);
    chk("t1_mem_addr",  mem_addr_v[DI],    32'h10);
    chk("t1_mem_wdata", mem_wdata_v[DI],   32'hDEADBEEF);
    ref_mem[DI][4] = 32'hDEADBEEF;
    @(negedge clk);
    drive(DI, 0, 0, 0, 0, 0);
    #2;
    chk("t1_mem_content", g_inst[DI].mem_g[4], 32'hDEADBEEF);
    chk_zero("t1_idle");

    // 2: both masters write continuously from a fresh reset
    @(negedge clk); areset = 1'b1;
    @(negedge clk); areset = 1'b0;
    c0 = 0; c1 = 0;
    for (int i = 0; i < 6; i++) begin
      drive(DI, 0, 1, 1, 32'h40 + 32'(8 * c0), 32'hA000_0000 + 32'(c0));
      drive(DI, 1, 1, 1, 32'h44 + 32'(8 * c1), 32'hB000_0000 + 32'(c1));
      #2;
      chk("t2_m0_gnt", 32'(m0_gnt_v[DI]), 32'((i % 2) == 0));
      chk("t2_m1_gnt", 32'(m1_gnt_v[DI]), 32'((i % 2) == 1));
      if ((i % 2) == 0) begin
        chk("t2_mem_addr", mem_addr_v[DI], 32'h40 + 32'(8 * c0));
        ref_mem[DI][16 + 2 * c0] = 32'hA000_0000 + 32'(c0);
        c0++;
      end else begin
        chk("t2_mem_addr", mem_addr_v[DI], 32'h44 + 32'(8 * c1));
        ref_mem[DI][17 + 2 * c1] = 32'hB000_0000 + 32'(c1);
        c1++;
      end
      @(negedge clk);
    end
    drive(DI, 0, 0, 0, 0, 0);
    drive(DI, 1, 0, 0, 0, 0);

    // 3: m1 read of 0x10 with RD_LATENCY=2
    drive(DI, 1, 1, 0, 32'h10, 0);
    for (int off = 0; off < 4; off++) begin
      #2;
      chk("t3_m1_gnt",    32'(m1_gnt_v[DI]),    32'(off == 0));
      chk("t3_busy",      32'(busy_v[DI]),      32'(off >= 1 && off <= LD));
      chk("t3_m1_rvalid", 32'(m1_rvalid_v[DI]), 32'(off == LD));
      chk("t3_m1_rdata",  m1_rdata_v[DI],       (off == LD) ? ref_mem[DI][4] : 32'h0);
      chk("t3_m0_rvalid", 32'(m0_rvalid_v[DI]), 0);
      @(negedge clk);
      if (off == 0) drive(DI, 1, 0, 0, 0, 0);
    end

    // 4: m0 read in flight, m1 write waits for the first IDLE cycle
    drive(DI, 0, 1, 0, 32'h40, 0);
    for (int off = 0; off < 5; off++) begin
      #2;
      chk("t4_m0_gnt",    32'(m0_gnt_v[DI]),    32'(off == 0));
      chk("t4_m1_gnt",    32'(m1_gnt_v[DI]),    32'(off == LD + 1));
      chk("t4_m0_rvalid", 32'(m0_rvalid_v[DI]), 32'(off == LD));
      chk("t4_m0_rdata",  m0_rdata_v[DI],       (off == LD) ? ref_mem[DI][16] : 32'h0);
      chk("t4_mem_we",    32'(mem_we_v[DI]),    32'(off == LD + 1));
      if (off == 4) chk("t4_mem_content", g_inst[DI].mem_g[20], 32'h1234_5678);
      @(negedge clk);
      if (off == 0) begin
        drive(DI, 0, 0, 0, 0, 0);
        drive(DI, 1, 1, 1, 32'h50, 32'h1234_5678);
      end
      if (off == LD + 1) drive(DI, 1, 0, 0, 0, 0);
    end
    ref_mem[DI][20] = 32'h1234_5678;

    // 5: reset the cycle after a read grant aborts the read
    drive(DI, 0, 1, 0, 32'h10, 0);
    #2 chk("t5_m0_gnt", 32'(m0_gnt_v[DI]), 1);
    @(negedge clk);
    drive(DI, 0, 0, 0, 0, 0);
    areset = 1'b1;
    #2 chk_zero("t5_rst");
    @(negedge clk);
    areset = 1'b0;
    for (int off = 0; off < LD + 2; off++) begin
      #2;
      chk("t5_m0_rvalid", 32'(m0_rvalid_v[DI]), 0);
      chk("t5_m1_rvalid", 32'(m1_rvalid_v[DI]), 0);
      chk("t5_busy",      32'(busy_v[DI]),      0);
      @(negedge clk);
    end
    drive(DI, 0, 1, 1, 32'h60, 32'h6060);
    drive(DI, 1, 1, 1, 32'h64, 32'h6464);
    #2;
    chk("t5_tie_m0_gnt", 32'(m0_gnt_v[DI]), 1);
    chk("t5_tie_m1_gnt", 32'(m1_gnt_v[DI]), 0);
    ref_mem[DI][24] = 32'h6060;
    @(negedge clk);
    drive(DI, 0, 0, 0, 0, 0);
    #2 chk("t5_next_m1_gnt", 32'(m1_gnt_v[DI]), 1);
    ref_mem[DI][25] = 32'h6464;
    @(negedge clk);
    drive(DI, 1, 0, 0, 0, 0);

    // 6: random mixed traffic on every latency
    for (int k = 0; k < NI; k++) begin
      lat = k + 1;
      for (int w = 32; w < 40; w++) begin
        dat = $urandom;
        drive(k, 0, 1, 1, 32'(4 * w), dat);
        #2 chk("t6_prefill_gnt", 32'(m0_gnt_v[k]), 1);
        ref_mem[k][w] = dat;
        @(negedge clk);
      end
      drive(k, 0, 0, 0, 0, 0);
      p0 = 0; p1 = 0; rvp = 0; rvid = 0; rvc = 0; rvd = '0;
      prev = 0; blk = -1;
      we0 = 0; we1 = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
      for (c = 0; c < 260; c++) begin
        gen = (c < 240);
        if (!p0 && gen && $urandom_range(2) == 0) begin
          p0 = 1; we0 = 1'($urandom_range(1));
          a0 = 32'h80 + 32'(4 * $urandom_range(7)); d0 = $urandom;
        end
        if (!p1 && gen && $urandom_range(2) == 0) begin
          p1 = 1; we1 = 1'($urandom_range(1));
          a1 = 32'h80 + 32'(4 * $urandom_range(7)); d1 = $urandom;
        end
        drive(k, 0, p0, we0, a0, d0);
        drive(k, 1, p1, we1, a1, d1);
        #2;
        g0 = 0; g1 = 0;
        if (c > blk) begin
          if (p0 && p1) begin
            if (prev == 1) g0 = 1; else g1 = 1;
          end else if (p0) g0 = 1;
          else if (p1) g1 = 1;
        end
        e0 = rvp && (c == rvc) && !rvid;
        e1 = rvp && (c == rvc) &&  rvid;
        chk("t6_m0_gnt",    32'(m0_gnt_v[k]),    32'(g0));
        chk("t6_m1_gnt",    32'(m1_gnt_v[k]),    32'(g1));
        chk("t6_mem_we",    32'(mem_we_v[k]),    32'((g0 && we0) || (g1 && we1)));
        chk("t6_m0_rvalid", 32'(m0_rvalid_v[k]), 32'(e0));
        chk("t6_m1_rvalid", 32'(m1_rvalid_v[k]), 32'(e1));
        chk("t6_m0_rdata",  m0_rdata_v[k],       e0 ? rvd : 32'h0);
        chk("t6_m1_rdata",  m1_rdata_v[k],       e1 ? rvd : 32'h0);
        if (rvp && c == rvc) rvp = 0;
        if (g0) begin
          prev = 0; p0 = 0;
          if (we0) ref_mem[k][a0[7:2]] = d0;
          else begin
            rvp = 1; rvid = 0; rvc = c + lat; rvd = ref_mem[k][a0[7:2]]; blk = c + lat;
          end
        end
        if (g1) begin
          prev = 1; p1 = 0;
          if (we1) ref_mem[k][a1[7:2]] = d1;
          else begin
            rvp = 1; rvid = 1; rvc = c + lat; rvd = ref_mem[k][a1[7:2]]; blk = c + lat;
          end
        end
        @(negedge clk);
      end
      drive(k, 0, 0, 0, 0, 0);
      drive(k, 1, 0, 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
